audio_fifo_ctrl: RTL

Controller for the audio sample FIFO (synchronous, registered read data, full/empty flags, no level output). It gates producer writes into the FIFO and mirrors the FIFO occupancy. It paces reads at the audio sample rate using a prefill/run/underrun state machine, and drives one sample per tick to the output serializer. It also raises a refill request toward the upstream producer (DMA or tone generator) when occupancy drops below a watermark.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_fifo_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared state encoding and default sizing for the audio FIFO path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 32;
    localparam int AUDIO_DEPTH      = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFILL  = 3'd1,
        ST_RUN      = 3'd2,
        ST_FETCH    = 3'd3,
        ST_UNDERRUN = 3'd4
    } audio_state_t;

endpackage

`default_nettype wire

// File: rtl/audio_fifo_ctrl.sv
// ============================================================================
// Module      : audio_fifo_ctrl
// Description : Gates producer writes into the sample FIFO, mirrors its level and
//               paces reads at the audio tick rate through a prefill/run FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_fifo_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH    = AUDIO_DATA_WIDTH,
    parameter int DEPTH         = AUDIO_DEPTH,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int PREFILL_LEVEL = 128,
    parameter int LOW_WATERMARK = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  sample_tick,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  refill_req,
    output logic [15:0]           underrun_cnt,
    output logic                  tick_miss,
    output logic [2:0]            state_o
);

    localparam int                 c_lvl_w       = ADDR_WIDTH + 1;
    localparam logic [c_lvl_w-1:0] c_full_lvl    = c_lvl_w'(DEPTH);
    localparam logic [c_lvl_w-1:0] c_prefill_lvl = c_lvl_w'(PREFILL_LEVEL);
    localparam logic [c_lvl_w-1:0] c_low_lvl     = c_lvl_w'(LOW_WATERMARK);

    audio_state_t          r_state;
    logic [c_lvl_w-1:0]    r_level;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic                  r_sample_valid;
    logic                  r_refill_req;
    logic [15:0]           r_underrun_cnt;
    logic                  r_tick_miss;

    logic w_can_read;
    logic w_rd_en;

    assign src_ready    = !fifo_full && (r_level != c_full_lvl);
    assign fifo_wr_en   = src_valid && src_ready;
    assign fifo_wr_data = src_data;

    // Read strobe is issued in the tick cycle itself so the FIFO's registered
    // data is ready for FETCH on the next cycle (tick -> sample_valid = 2 cycles).
    assign w_can_read = (r_level != '0) && !fifo_empty;
    assign w_rd_en    = (r_state == ST_RUN) && enable && sample_tick && w_can_read;
    assign fifo_rd_en = w_rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({fifo_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_refill_req   <= 1'b0;
            r_underrun_cnt <= '0;
            r_tick_miss    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_refill_req   <= enable && (r_level < c_low_lvl);
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (!enable)                      r_state <= ST_IDLE;
                    else if (r_level >= c_prefill_lvl) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable)                        r_state <= ST_IDLE;
                    else if (sample_tick && w_can_read) r_state <= ST_FETCH;
                    else if (sample_tick)               r_state <= ST_UNDERRUN;
                end
                ST_FETCH: begin
                    r_sample_out   <= fifo_rd_data;
                    r_sample_valid <= 1'b1;
                    // Only one read may be in flight, so a tick here is lost.
                    if (sample_tick) r_tick_miss <= 1'b1;
                    r_state <= enable ? ST_RUN : ST_IDLE;
                end
                ST_UNDERRUN: begin
                    r_sample_out   <= '0;
                    r_sample_valid <= 1'b1;
                    if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
                    r_state <= enable ? ST_PREFILL : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign refill_req   = r_refill_req;
    assign underrun_cnt = r_underrun_cnt;
    assign tick_miss    = r_tick_miss;
    assign state_o      = r_state;

endmodule

`default_nettype wire
